// File: rtl/core_mem_pkg.sv
// Shared widths and constants for the unified instruction/data memory and its
// transmit MMIO register.
package core_mem_pkg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned LANES     = DATA_W / 8;
  localparam int unsigned LANE_BITS = $clog2(LANES);

  // All-ones byte address aligned down to a word boundary.
  localparam logic [ADDR_W-1:0] MMIO_TX_ADDR_DEFAULT = ~ADDR_W'(LANES - 1);

  function automatic logic [ADDR_W-1:0] word_of(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr >> LANE_BITS;
  endfunction

endpackage

// File: rtl/core_mem_if.sv
// Core-side bus of core_mem: fetch and load/store ports plus the transmit stream.
interface core_mem_if;
  import core_mem_pkg::*;

  logic [ADDR_W-1:0] pc_to_mem;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] st_data;
  logic [LANES-1:0]  we;
  logic [DATA_W-1:0] ld_data_for_inst;
  logic [DATA_W-1:0] ld_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              txq_full;

  modport master (
    output pc_to_mem, mem_addr, st_data, we, tx_ready,
    input  ld_data_for_inst, ld_data, tx_data, tx_valid, txq_full
  );

  modport slave (
    input  pc_to_mem, mem_addr, st_data, we, tx_ready,
    output ld_data_for_inst, ld_data, tx_data, tx_valid, txq_full
  );

endinterface

// File: rtl/core_mem_txq.sv
// Byte FIFO behind the transmit MMIO register; extra pointer bit separates full from empty.
module core_mem_txq #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       pop,
  output logic [7:0] data,
  output logic       valid,
  output logic       full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wptr_q, rptr_q;
  logic [7:0]  store_q [DEPTH];
  logic        empty, do_push, do_pop;

  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

  // Pop needs an entry already present, so push+pop on empty is never a pass-through;
  // on full the pop frees the slot the push lands in.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && do_push) store_q[wptr_q[AW-1:0]] <= push_data;
  end

  assign valid = !empty;
  assign data  = empty ? 8'h00 : store_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/core_mem.sv
// Unified instruction/data array with per-port fixed-latency read pipelines,
// byte-lane stores and a memory-mapped transmit FIFO.
module core_mem
  import core_mem_pkg::*;
#(
  parameter int unsigned       LOAD_LATENCY = 1,
  parameter int unsigned       MEM_WORDS    = 4096,
  parameter logic [ADDR_W-1:0] MMIO_TX_ADDR = MMIO_TX_ADDR_DEFAULT,
  parameter int unsigned       TXQ_DEPTH    = 8
) (
  input logic       clk,
  input logic       rst,
  core_mem_if.slave bus
);

  // MEM_WORDS is a power of two, so truncating the word number wraps the index.
  localparam int unsigned IdxW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [DATA_W-1:0] mem [MEM_WORDS];
  logic [DATA_W-1:0] inst_pipe_q [LOAD_LATENCY];
  logic [DATA_W-1:0] data_pipe_q [LOAD_LATENCY];

  logic [IdxW-1:0]   inst_idx, data_idx;
  logic [DATA_W-1:0] data_rd;
  logic              is_mmio, is_store, mem_write, tx_push;
  logic [7:0]        tx_data;
  logic              tx_valid, txq_full;

  assign inst_idx  = IdxW'(word_of(bus.pc_to_mem));
  assign data_idx  = IdxW'(word_of(bus.mem_addr));
  assign is_mmio   = (bus.mem_addr == MMIO_TX_ADDR);
  assign is_store  = |bus.we;
  assign mem_write = is_store && !is_mmio;
  assign tx_push   = is_store && is_mmio && bus.we[0];

  assign data_rd = is_mmio ? {{(DATA_W-2){1'b0}}, txq_full, tx_valid} : mem[data_idx];

  // Reads sample mem in the same edge as the write, which yields read-before-write.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LOAD_LATENCY; i++) begin
        inst_pipe_q[i] <= '0;
        data_pipe_q[i] <= '0;
      end
    end else begin
      inst_pipe_q[0] <= mem[inst_idx];
      data_pipe_q[0] <= data_rd;
      for (int i = 1; i < LOAD_LATENCY; i++) begin
        inst_pipe_q[i] <= inst_pipe_q[i-1];
        data_pipe_q[i] <= data_pipe_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mem_write) begin
      for (int i = 0; i < LANES; i++) begin
        if (bus.we[i]) mem[data_idx][8*i +: 8] <= bus.st_data[8*i +: 8];
      end
    end
  end

  core_mem_txq #(
    .DEPTH(TXQ_DEPTH)
  ) u_txq (
    .clk      (clk),
    .rst      (rst),
    .push     (tx_push),
    .push_data(bus.st_data[7:0]),
    .pop      (bus.tx_ready),
    .data     (tx_data),
    .valid    (tx_valid),
    .full     (txq_full)
  );

  assign bus.ld_data_for_inst = inst_pipe_q[LOAD_LATENCY-1];
  assign bus.ld_data          = data_pipe_q[LOAD_LATENCY-1];
  assign bus.tx_data          = tx_data;
  assign bus.tx_valid         = tx_valid;
  assign bus.txq_full         = txq_full;

endmodule

// File: tb/tb_core_mem.sv
// Scoreboard bench: three core_mem instances (load latency 1, 2, 3) share one stimulus.
module tb_core_mem;
  import core_mem_pkg::*;

  localparam int unsigned NWORDS = 64;
  localparam int unsigned NDUT   = 3;
  localparam int unsigned QDEPTH = 8;
  localparam logic [ADDR_W-1:0] MMIO = MMIO_TX_ADDR_DEFAULT;

  logic              clk = 1'b0;
  logic              rst;
  logic [ADDR_W-1:0] pc, addr;
  logic [DATA_W-1:0] st;
  logic [LANES-1:0]  we;
  logic              tx_ready;

  logic [DATA_W-1:0] inst_o [NDUT];
  logic [DATA_W-1:0] ld_o   [NDUT];
  logic [7:0]        txd_o  [NDUT];
  logic              txv_o  [NDUT];
  logic              txf_o  [NDUT];

  always #5 clk = ~clk;

  core_mem_if bus [NDUT] ();

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    core_mem #(
      .LOAD_LATENCY(g + 1),
      .MEM_WORDS   (NWORDS),
      .MMIO_TX_ADDR(MMIO),
      .TXQ_DEPTH   (QDEPTH)
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(bus[g])
    );
    assign bus[g].pc_to_mem = pc;
    assign bus[g].mem_addr  = addr;
    assign bus[g].st_data   = st;
    assign bus[g].we        = we;
    assign bus[g].tx_ready  = tx_ready;
    assign inst_o[g] = bus[g].ld_data_for_inst;
    assign ld_o[g]   = bus[g].ld_data;
    assign txd_o[g]  = bus[g].tx_data;
    assign txv_o[g]  = bus[g].tx_valid;
    assign txf_o[g]  = bus[g].txq_full;
  end

  typedef struct {
    int unsigned       due;
    bit                ok_i;
    bit                ok_d;
    logic [DATA_W-1:0] inst;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic [DATA_W-1:0] mdl_mem [NWORDS];
  bit                known   [NWORDS];
  logic [7:0]        txq [$];
  exp_t              sb  [NDUT][$];
  int unsigned       cyc = 0;
  int unsigned       n_checks = 0;
  int unsigned       n_pass = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] obs,
                       input logic [DATA_W-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %h required %h (cycle %0d)", tag, obs, exp, cyc);
  endtask

  function automatic int idx_of(input logic [ADDR_W-1:0] a);
    return int'((a >> LANE_BITS) % NWORDS);
  endfunction

  // Reference behaviour of one clock edge, evaluated with the pre-edge inputs.
  task automatic model_edge();
    exp_t              e;
    int                pi, di;
    bit                pop;
    logic [DATA_W-1:0] status;
    pi = idx_of(pc);
    di = idx_of(addr);
    status    = '0;
    status[1] = (txq.size() == QDEPTH);
    status[0] = (txq.size() != 0);
    e.inst = rst ? '0 : mdl_mem[pi];
    e.ok_i = rst || known[pi];
    if (addr == MMIO) begin
      e.data = rst ? '0 : status;
      e.ok_d = 1'b1;
    end else begin
      e.data = rst ? '0 : mdl_mem[di];
      e.ok_d = rst || known[di];
    end
    for (int d = 0; d < NDUT; d++) begin
      e.due = cyc + d + 1;
      sb[d].push_back(e);
    end
    if (rst) begin
      for (int d = 0; d < NDUT; d++) begin
        foreach (sb[d][k]) begin
          sb[d][k].inst = '0;
          sb[d][k].data = '0;
          sb[d][k].ok_i = 1'b1;
          sb[d][k].ok_d = 1'b1;
        end
      end
      txq.delete();
      return;
    end
    pop = tx_ready && (txq.size() != 0);
    if (pop) begin
      for (int d = 0; d < NDUT; d++)
        check($sformatf("tx_pop[L%0d]", d + 1), DATA_W'(txd_o[d]), DATA_W'(txq[0]));
    end
    if (we != '0) begin
      if (addr == MMIO) begin
        if (we[0] && (txq.size() < QDEPTH || pop)) txq.push_back(st[7:0]);
      end else begin
        for (int i = 0; i < LANES; i++)
          if (we[i]) mdl_mem[di][8*i +: 8] = st[8*i +: 8];
        if (we == '1) known[di] = 1'b1;
      end
    end
    if (pop) void'(txq.pop_front());
  endtask

  task automatic check_outputs();
    exp_t e;
    for (int d = 0; d < NDUT; d++) begin
      while (sb[d].size() != 0 && sb[d][0].due <= cyc) begin
        e = sb[d].pop_front();
        if (e.ok_i) check($sformatf("fetch[L%0d]", d + 1), inst_o[d], e.inst);
        if (e.ok_d) check($sformatf("load[L%0d]", d + 1), ld_o[d], e.data);
      end
      check($sformatf("tx_valid[L%0d]", d + 1), DATA_W'(txv_o[d]), DATA_W'(txq.size() != 0));
      check($sformatf("txq_full[L%0d]", d + 1), DATA_W'(txf_o[d]),
            DATA_W'(txq.size() == QDEPTH));
      check($sformatf("tx_data[L%0d]", d + 1), DATA_W'(txd_o[d]),
            (txq.size() != 0) ? DATA_W'(txq[0]) : '0);
    end
  endtask

  task automatic drive(input logic r, input logic [ADDR_W-1:0] p, input logic [ADDR_W-1:0] a,
                       input logic [DATA_W-1:0] s, input logic [LANES-1:0] w, input logic rdy);
    rst = r; pc = p; addr = a; st = s; we = w; tx_ready = rdy;
    model_edge();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  function automatic logic [DATA_W-1:0] fill_word(input int i);
    if (i == 0) return 32'h0000_1234;
    if (i == 2) return 32'hFFFF_FFFF;
    return 32'hA500_0000 ^ (DATA_W'(i) * 32'h0101_0101);
  endfunction

  initial begin
    rst = 1'b1; pc = '0; addr = '0; st = '0; we = '0; tx_ready = 1'b0;
    repeat (2) drive(1'b1, '0, '0, '0, '0, 1'b0);

    for (int i = 0; i < NWORDS; i++)
      drive(1'b0, ADDR_W'(i * 4), ADDR_W'(i * 4 + 1), fill_word(i), '1, 1'b0);

    // Three queued bytes and a load in flight when reset hits; the store under reset is ignored.
    for (int b = 0; b < 3; b++) drive(1'b0, '0, MMIO, 32'h31 + DATA_W'(b), 4'b0001, 1'b0);
    drive(1'b0, '0, 32'h14, '0, '0, 1'b0);
    drive(1'b1, '0, 32'h14, 32'hDEAD_BEEF, '1, 1'b0);
    repeat (4) drive(1'b0, '0, 32'h14, '0, '0, 1'b0);

    // Lane-0 clear of word 2 with same-cycle reads on both ports, then a wrapped re-read.
    drive(1'b0, 32'h8, 32'h8, '0, 4'b0001, 1'b0);
    drive(1'b0, 32'h8, 32'h8, '0, '0, 1'b0);
    drive(1'b0, 32'h108, 32'h0000_0308, '0, '0, 1'b0);
    for (int i = 0; i < 8; i++)
      drive(1'b0, ADDR_W'(i * 4), ADDR_W'(i * 8 + 3), '0, '0, 1'b0);

    for (int n = 0; n < 300; n++) begin
      logic [ADDR_W-1:0] ra;
      logic [LANES-1:0]  rw;
      ra = $urandom() & 32'h7FFF_FFFF;
      if ($urandom_range(0, 5) == 0) ra = MMIO;
      rw = ($urandom_range(0, 2) == 0) ? LANES'($urandom_range(1, 15)) : '0;
      drive(1'b0, $urandom(), ra, $urandom(), rw, 1'($urandom_range(0, 1)));
    end

    repeat (10) drive(1'b0, '0, MMIO, '0, '0, 1'b1);
    for (int b = 0; b < 9; b++) drive(1'b0, '0, MMIO, 32'h41 + DATA_W'(b), 4'b0001, 1'b0);
    repeat (10) drive(1'b0, '0, MMIO, '0, '0, 1'b1);

    for (int b = 0; b < 8; b++) drive(1'b0, '0, MMIO, 32'h61 + DATA_W'(b), 4'b0001, 1'b0);
    drive(1'b0, '0, MMIO, 32'h50, 4'b0001, 1'b1);
    drive(1'b0, '0, MMIO, '0, '0, 1'b0);
    repeat (10) drive(1'b0, '0, MMIO, '0, '0, 1'b1);

    drive(1'b0, '0, MMIO, 32'h77, 4'b0001, 1'b1);
    drive(1'b0, '0, MMIO, 32'h88, 4'b0010, 1'b0);
    drive(1'b0, '0, MMIO, '0, '0, 1'b0);
    repeat (3) drive(1'b0, '0, MMIO, '0, '0, 1'b1);

    repeat (4) drive(1'b0, 32'h4, 32'hC, '0, '0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/core_mem.md
CORE_MEM -- requirements
Module: core_mem

Interface
REQ-001 Parameter LOAD_LATENCY, default 1, read latency in cycles (legal 1..3), matching the core's load latency.
REQ-002 Parameter MEM_WORDS, default 4096, number of DATA_W-bit words in the unified instruction/data array.
REQ-003 Parameter MMIO_TX_ADDR, default all-ones byte address aligned down to DATA_W/8, the transmit-register address.
REQ-004 Parameter TXQ_DEPTH, default 8, power of two, transmit FIFO depth.
REQ-005 Clocking and reset are fixed: one clock; reset is synchronous and active-high.
REQ-006 clk  input  1  sole clock; all state updates on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 pc_to_mem  input  ADDR_W  instruction fetch byte address.
REQ-009 mem_addr  input  ADDR_W  data load/store byte address.
REQ-010 st_data  input  DATA_W  store data.
REQ-011 we  input  DATA_W/8  per-byte write enables; zero means a load.
REQ-012 ld_data_for_inst  output  DATA_W  fetched instruction word.
REQ-013 ld_data  output  DATA_W  loaded data word.
REQ-014 tx_data  output  8  byte at the head of the transmit FIFO.
REQ-015 tx_valid  output  1  transmit FIFO is non-empty.
REQ-016 tx_ready  input  1  consumer accepts tx_data this cycle.
REQ-017 txq_full  output  1  transmit FIFO holds TXQ_DEPTH entries.

Function
REQ-018 Word index is the byte address shifted right by log2(DATA_W/8); low address bits are ignored; index wraps modulo MEM_WORDS.
REQ-019 Fetch and data ports read every cycle; each result appears exactly LOAD_LATENCY cycles after its address is presented, through a LOAD_LATENCY-deep register pipeline per port.
REQ-020 When we != 0 and mem_addr != MMIO_TX_ADDR, each byte lane i with we[i]=1 is written at the clock edge; lanes with we[i]=0 are unchanged.
REQ-021 A same-cycle read of a word being written (either port) returns the pre-write contents (read-before-write).
REQ-022 A read issued the cycle after a write to the same word returns the new contents.
REQ-023 A store to MMIO_TX_ADDR with we[0]=1 pushes st_data[7:0] into the transmit FIFO; the array is not written.
REQ-024 A push while txq_full=1 is dropped; FIFO contents, pointers, and the array are unchanged.
REQ-025 A pop occurs when tx_valid=1 and tx_ready=1; tx_data advances to the next entry on the following cycle.
REQ-026 A simultaneous push and pop when full is accepted: occupancy stays TXQ_DEPTH.
REQ-027 A simultaneous push and pop when empty is not a pass-through: the pop is ignored and occupancy becomes 1.
REQ-028 A load from MMIO_TX_ADDR returns {zeros, txq_full, tx_valid} in bits [1:0] after LOAD_LATENCY cycles.
REQ-029 FIFO read/write pointers are log2(TXQ_DEPTH)+1 bits wide and wrap naturally; full and empty are derived from the pointers.

Reset
REQ-030 While rst=1: ld_data_for_inst=0, ld_data=0, tx_valid=0, txq_full=0, tx_data=0, and all read-pipeline stages are 0.
REQ-031 Reset empties the FIFO (pointers = 0) and does not clear the memory array.
REQ-032 A store presented in a cycle with rst=1 is ignored.
REQ-033 Reads in flight when rst is asserted are discarded and are not delivered after reset.

Structure
REQ-034 DATA_W and ADDR_W come from the shared common_params header; the MMIO address default and the lane count DATA_W/8 are defined there as shared constants.
REQ-035 The transmit FIFO is a separate sub-module named core_mem_txq; the array and read pipelines stay in core_mem.

Verification
REQ-036 Reset, then fetch at 0x0 with the array preloaded to 0x1234 at word 0 -> ld_data_for_inst=0x1234 exactly LOAD_LATENCY cycles later; outputs are 0 during reset.
REQ-037 Word 2 holds all-ones; store with we=0b0001 and st_data=0 at byte address 2*(DATA_W/8), then load it -> only byte 0 is cleared; a same-cycle load returns all-ones.
REQ-038 Push 9 bytes 0x41..0x49 with tx_ready=0 and TXQ_DEPTH=8 -> txq_full=1 after the 8th; 0x49 is dropped; draining yields 0x41..0x48.
REQ-039 FIFO full, push 0x50 and pop in the same cycle -> occupancy stays 8 and 0x50 becomes the last entry drained.
REQ-040 Assert rst for 1 cycle with FIFO holding 3 entries and a load in flight -> tx_valid=0 next cycle; no stale ld_data appears; array contents are preserved.
REQ-041 Sweep LOAD_LATENCY over 1, 2, and 3 with back-to-back loads of distinct words -> each result arrives at exactly its latency, in order, with no bubbles.
